// File: rtl/ex_pkg.sv
// Shared definitions for the RV32 execute stage: ALU opcodes, control-bundle
// bit positions, multiplier FSM encoding and the default datapath width.
package ex_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  localparam int CTRL_W        = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEM2REG  = 1;
  localparam int CTRL_REGWRITE = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // A producer only forwards when it really writes a non-x0 register.
  function automatic logic fwd_match(input logic       wen,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return wen && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier (one partial product per cycle, low XLEN bits
// kept). Exposes its FSM state on state_o.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o,
  output mul_state_e      state_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (flush_i) begin
      state_q <= MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= MUL_DONE;
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  // Handshake: start_i is a level sampled only in IDLE; busy_o covers the
  // accepting IDLE cycle plus every BUSY cycle and drops combinationally on
  // flush or reset; done_o marks the single cycle in which product_o is final.
  assign busy_o    = !rst && !flush_i &&
                     (((state_q == MUL_IDLE) && start_i) || (state_q == MUL_BUSY));
  assign done_o    = (state_q == MUL_DONE) && !flush_i;
  assign product_o = acc_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding, ALU, iterative multiply and the EX/MEM
// register. Define EX_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_IDEX,
  input  logic [XLEN-1:0] rs1_data_IDEX,
  input  logic [XLEN-1:0] rs2_data_IDEX,
  input  logic [XLEN-1:0] imm_IDEX,
  input  logic [4:0]      rs1_IDEX,
  input  logic [4:0]      rs2_IDEX,
  input  logic [4:0]      rd_IDEX,
  input  logic [3:0]      aluCtrl_IDEX,
  input  logic            aluSrc_IDEX,
  input  logic [4:0]      ctrl_IDEX,
  input  logic [4:0]      rd_MEMWB,
  input  logic            RegWrite_MEMWB,
  input  logic [XLEN-1:0] wb_Data_MEMWB,
  output logic            stall_EX,
  output logic [XLEN-1:0] read_Address_EXMEM,
  output logic [XLEN-1:0] write_Data_EXMEM,
  output logic [4:0]      rd_EXMEM,
  output logic            zero_EXMEM,
  output logic [XLEN-1:0] branchTarget_EXMEM,
  output logic [4:0]      ctrl_EXMEM
);

  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] target_q;
  logic [4:0]      rd_q;
  logic [4:0]      ctrl_q;
  logic            zero_q;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic [4:0]      shamt;
  logic            mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;
  mul_state_e      dbg_state_unused;

`ifdef EX_FWD_EN
  always_comb begin
    fwd_a = rs1_data_IDEX;
    if (fwd_match(ctrl_q[CTRL_REGWRITE], rd_q, rs1_IDEX))
      fwd_a = res_q;
    else if (fwd_match(RegWrite_MEMWB, rd_MEMWB, rs1_IDEX))
      fwd_a = wb_Data_MEMWB;

    fwd_b = rs2_data_IDEX;
    if (fwd_match(ctrl_q[CTRL_REGWRITE], rd_q, rs2_IDEX))
      fwd_b = res_q;
    else if (fwd_match(RegWrite_MEMWB, rd_MEMWB, rs2_IDEX))
      fwd_b = wb_Data_MEMWB;
  end
`else
  // Hazard-free schedule guaranteed upstream: operands come straight from ID/EX.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs1_IDEX, rs2_IDEX, rd_MEMWB, RegWrite_MEMWB, wb_Data_MEMWB};
  assign fwd_a = rs1_data_IDEX;
  assign fwd_b = rs2_data_IDEX;
`endif

  assign op_b  = aluSrc_IDEX ? imm_IDEX : fwd_b;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (aluCtrl_IDEX)
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_XOR: alu_res = fwd_a ^ op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLL: alu_res = fwd_a << shamt;
      ALU_SRL: alu_res = fwd_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(fwd_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (aluCtrl_IDEX == ALU_MUL),
    .flush_i   (flush),
    .a_i       (fwd_a),
    .b_i       (fwd_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product),
    .state_o   (dbg_state_unused)
  );

  assign stall_EX = mul_busy;
  assign res_d    = mul_done ? mul_product : alu_res;

  // Flush and stall both turn the EX/MEM slot into an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      zero_q   <= 1'b0;
    end else if (flush || mul_busy) begin
      res_q    <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      res_q    <= res_d;
      wdata_q  <= fwd_b;
      target_q <= pc_IDEX + imm_IDEX;
      rd_q     <= rd_IDEX;
      ctrl_q   <= ctrl_IDEX;
      zero_q   <= (res_d == '0);
    end
  end

  assign read_Address_EXMEM = res_q;
  assign write_Data_EXMEM   = wdata_q;
  assign branchTarget_EXMEM = target_q;
  assign rd_EXMEM           = rd_q;
  assign ctrl_EXMEM         = ctrl_q;
  assign zero_EXMEM         = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, forwarding, iterative
// multiply stall timing, flush and asynchronous reset.
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        flush;
  logic [31:0] pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX, ctrl_IDEX, rd_MEMWB;
  logic [3:0]  aluCtrl_IDEX;
  logic        aluSrc_IDEX, RegWrite_MEMWB;
  logic [31:0] wb_Data_MEMWB;
  logic        stall_EX, zero_EXMEM;
  logic [31:0] read_Address_EXMEM, write_Data_EXMEM, branchTarget_EXMEM;
  logic [4:0]  rd_EXMEM, ctrl_EXMEM;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_IDEX(pc_IDEX),
    .rs1_data_IDEX(rs1_data_IDEX), .rs2_data_IDEX(rs2_data_IDEX), .imm_IDEX(imm_IDEX),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .aluCtrl_IDEX(aluCtrl_IDEX), .aluSrc_IDEX(aluSrc_IDEX), .ctrl_IDEX(ctrl_IDEX),
    .rd_MEMWB(rd_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB), .wb_Data_MEMWB(wb_Data_MEMWB),
    .stall_EX(stall_EX), .read_Address_EXMEM(read_Address_EXMEM),
    .write_Data_EXMEM(write_Data_EXMEM), .rd_EXMEM(rd_EXMEM), .zero_EXMEM(zero_EXMEM),
    .branchTarget_EXMEM(branchTarget_EXMEM), .ctrl_EXMEM(ctrl_EXMEM)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] ctrl);
    aluCtrl_IDEX  = op;
    rs1_data_IDEX = a;
    rs2_data_IDEX = b;
    imm_IDEX      = imm;
    aluSrc_IDEX   = src;
    rs1_IDEX      = rs1;
    rs2_IDEX      = rs2;
    rd_IDEX       = rd;
    ctrl_IDEX     = ctrl;
  endtask

  // ALU vector table: A, immediate B, expected result
  logic [3:0]  t_op [10];
  logic [31:0] t_a  [10];
  logic [31:0] t_b  [10];
  logic [31:0] t_e  [10];

  initial begin
    t_op[0] = ALU_AND; t_a[0] = 32'h0000F0F0; t_b[0] = 32'h00000FF0; t_e[0] = 32'h000000F0;
    t_op[1] = ALU_OR;  t_a[1] = 32'h0000F000; t_b[1] = 32'h0000000F; t_e[1] = 32'h0000F00F;
    t_op[2] = ALU_XOR; t_a[2] = 32'hFF00FF00; t_b[2] = 32'h0F0F0F0F; t_e[2] = 32'hF00FF00F;
    t_op[3] = ALU_SLT; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'h00000001; t_e[3] = 32'h00000001;
    t_op[4] = ALU_SLT; t_a[4] = 32'h00000001; t_b[4] = 32'hFFFFFFFF; t_e[4] = 32'h00000000;
    t_op[5] = ALU_SLL; t_a[5] = 32'h00000001; t_b[5] = 32'h0000001F; t_e[5] = 32'h80000000;
    t_op[6] = ALU_SLL; t_a[6] = 32'h00000001; t_b[6] = 32'h00000021; t_e[6] = 32'h00000002;
    t_op[7] = ALU_SRL; t_a[7] = 32'h80000000; t_b[7] = 32'h00000004; t_e[7] = 32'h08000000;
    t_op[8] = ALU_SRA; t_a[8] = 32'h80000000; t_b[8] = 32'h00000004; t_e[8] = 32'hF8000000;
    t_op[9] = 4'b0100; t_a[9] = 32'h00000005; t_b[9] = 32'h00000003; t_e[9] = 32'h00000000;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int stall_cnt, edges, bubble_bad;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pc_IDEX = 32'h0;
    rd_MEMWB = 5'd0;
    RegWrite_MEMWB = 1'b0;
    wb_Data_MEMWB = 32'h0;
    set_instr(ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_res",    read_Address_EXMEM, 32'h0);
    check("rst_wdata",  write_Data_EXMEM,   32'h0);
    check("rst_rd",     rd_EXMEM,           32'h0);
    check("rst_ctrl",   ctrl_EXMEM,         32'h0);
    check("rst_zero",   zero_EXMEM,         32'h0);
    check("rst_target", branchTarget_EXMEM, 32'h0);
    check("rst_stall",  stall_EX,           32'h0);
    rst = 1'b0;

    // ADD with immediate, then SUB giving zero
    pc_IDEX = 32'h100;
    set_instr(ALU_ADD, 32'd5, 32'h1234, 32'hFFFFFFF9, 1'b1, 5'd0, 5'd0, 5'd5, 5'b00001);
    tick();
    check("add_res",    read_Address_EXMEM, 32'hFFFFFFFE);
    check("add_zero",   zero_EXMEM,         32'h0);
    check("add_rd",     rd_EXMEM,           32'd5);
    check("add_ctrl",   ctrl_EXMEM,         32'h1);
    check("add_target", branchTarget_EXMEM, 32'h000000F9);
    check("add_wdata",  write_Data_EXMEM,   32'h1234);
    set_instr(ALU_SUB, 32'd9, 32'd9, 32'h0, 1'b0, 5'd7, 5'd8, 5'd6, 5'b00001);
    tick();
    check("sub_res",  read_Address_EXMEM, 32'h0);
    check("sub_zero", zero_EXMEM,         32'h1);

    // forwarding: EX/MEM beats MEM/WB, then MEM/WB alone
    set_instr(ALU_ADD, 32'd4, 32'd6, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 5'b00001);
    tick();
    check("fwd_add_res", read_Address_EXMEM, 32'd10);
    set_instr(ALU_SUB, 32'hDEAD, 32'd4, 32'h0, 1'b0, 5'd3, 5'd1, 5'd4, 5'b00001);
    rd_MEMWB = 5'd3; RegWrite_MEMWB = 1'b1; wb_Data_MEMWB = 32'd99;
    tick();
    check("fwd_exmem_prio", read_Address_EXMEM, FWD ? 32'd6 : 32'h0000DEA9);
    check("fwd_wdata",      write_Data_EXMEM,   32'd4);
    rd_MEMWB = 5'd9; wb_Data_MEMWB = 32'd50;
    set_instr(ALU_ADD, 32'd7, 32'd3, 32'h0, 1'b0, 5'd9, 5'd0, 5'd5, 5'b00001);
    tick();
    check("fwd_memwb", read_Address_EXMEM, FWD ? 32'd53 : 32'd10);

    // x0 destinations never forward
    RegWrite_MEMWB = 1'b0;
    set_instr(ALU_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 5'd12, 5'd13, 5'd0, 5'b00001);
    tick();
    check("rd0_rd",  rd_EXMEM,           32'd0);
    check("rd0_res", read_Address_EXMEM, 32'd2);
    rd_MEMWB = 5'd0; RegWrite_MEMWB = 1'b1; wb_Data_MEMWB = 32'h999;
    set_instr(ALU_ADD, 32'h11, 32'h22, 32'h0, 1'b0, 5'd0, 5'd0, 5'd10, 5'b00001);
    tick();
    check("rd0_nofwd", read_Address_EXMEM, 32'h33);
    RegWrite_MEMWB = 1'b0;

    // ALU table, immediate operand, no RegWrite
    for (int i = 0; i < 10; i++) begin
      set_instr(t_op[i], t_a[i], 32'h0, t_b[i], 1'b1, 5'd0, 5'd0, 5'd1, 5'b00000);
      tick();
      check($sformatf("alu%0d_res", i),  read_Address_EXMEM, t_e[i]);
      check($sformatf("alu%0d_zero", i), zero_EXMEM, (t_e[i] == 32'h0) ? 32'h1 : 32'h0);
    end

    // MUL 0xFFFF x 0x10001: 33 stall cycles, product on edge 34
    set_instr(ALU_MUL, 32'h0000FFFF, 32'h00010001, 32'h0, 1'b0, 5'd10, 5'd11, 5'd7, 5'b00001);
    #1;
    stall_cnt = 0; edges = 0; bubble_bad = 0;
    while (stall_EX && edges < 100) begin
      stall_cnt++;
      tick();
      edges++;
      if (ctrl_EXMEM != 5'd0 || rd_EXMEM != 5'd0) bubble_bad++;
    end
    check("mul_stall_cycles", stall_cnt,  32'd33);
    check("mul_done_edge",    edges,      32'd33);
    check("mul_bubbles",      bubble_bad, 32'd0);
    tick();
    check("mul_product", read_Address_EXMEM, 32'hFFFFFFFF);
    check("mul_rd",      rd_EXMEM,           32'd7);
    check("mul_ctrl",    ctrl_EXMEM,         32'h1);
    set_instr(ALU_AND, 0, 0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 5'b00000);
    #1;
    check("mul_stall_clear", stall_EX, 32'h0);

    // flush while BUSY at count 10
    set_instr(ALU_MUL, 32'd3, 32'd5, 32'h0, 1'b0, 5'd10, 5'd11, 5'd8, 5'b00001);
    for (int i = 0; i < 11; i++) tick();
    check("flush_pre_cnt",   dut.u_mul.cnt_q, 32'd10);
    check("flush_pre_stall", stall_EX,        32'h1);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", stall_EX, 32'h0);
    tick();
    check("flush_bubble_ctrl", ctrl_EXMEM,         32'h0);
    check("flush_bubble_rd",   rd_EXMEM,           32'h0);
    check("flush_fsm_idle",    dut.u_mul.state_o,  32'(MUL_IDLE));
    flush = 1'b0;
    set_instr(ALU_ADD, 32'd20, 32'h0, 32'd22, 1'b1, 5'd0, 5'd0, 5'd9, 5'b00001);
    #1;
    check("flush_add_nostall", stall_EX, 32'h0);
    tick();
    check("flush_add_res", read_Address_EXMEM, 32'd42);
    check("flush_add_rd",  rd_EXMEM,           32'd9);

    // asynchronous reset in the middle of a multiply
    set_instr(ALU_MUL, 32'd6, 32'd7, 32'h0, 1'b0, 5'd10, 5'd11, 5'd3, 5'b00001);
    for (int i = 0; i < 5; i++) tick();
    check("rstmul_pre_stall", stall_EX, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmul_stall",  stall_EX,           32'h0);
    check("rstmul_res",    read_Address_EXMEM, 32'h0);
    check("rstmul_ctrl",   ctrl_EXMEM,         32'h0);
    check("rstmul_target", branchTarget_EXMEM, 32'h0);
    check("rstmul_state",  dut.u_mul.state_o,  32'(MUL_IDLE));
    tick();
    rst = 1'b0;
    set_instr(ALU_AND, 32'hF0, 32'h3C, 32'h0, 1'b0, 5'd0, 5'd0, 5'd2, 5'b00001);
    #1;
    check("rstmul_and_nostall", stall_EX, 32'h0);
    tick();
    check("rstmul_and_res", read_Address_EXMEM, 32'h30);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
